// File: rtl/elbeth_pc_pkg.sv
// Shared types and constants for the elbeth program-counter unit.
package elbeth_pc_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } pc_state_t;

    localparam int STEP16 = 2;
    localparam int STEP32 = 4;

    typedef enum logic [1:0] {
        SEL_SEQ    = 2'd0,
        SEL_BRANCH = 2'd1,
        SEL_ERET   = 2'd2,
        SEL_EXC    = 2'd3
    } redir_sel_t;

endpackage

// File: rtl/elbeth_pc_incr.sv
// Sequential-PC incrementer: adds 2 for compressed instructions when C_EXT is set, else 4.
module elbeth_pc_incr
    import elbeth_pc_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter bit C_EXT = 1'b0
) (
    input  logic [XLEN-1:0] pc,
    input  logic            compressed,
    output logic [XLEN-1:0] sum
);

    logic [XLEN-1:0] step;

    assign step = (C_EXT && compressed) ? XLEN'(STEP16) : XLEN'(STEP32);
    assign sum  = pc + step;

endmodule

// File: rtl/elbeth_pc_unit.sv
// Program-counter unit at the head of fetch: PC register, redirect mux,
// BOOT/RUN/HALT sequencing and fetch handshake.
//
//   state   | meaning
//   --------+-----------------------------------------------
//   ST_BOOT | first cycle after reset, no fetch request
//   ST_RUN  | fetching; PC advances on acceptance
//   ST_HALT | no fetch request; redirects still load the PC
module elbeth_pc_unit
    import elbeth_pc_pkg::*;
#(
    parameter int          XLEN         = 32,
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0100,
    parameter bit          C_EXT        = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fetch_ready_i,
    input  logic            stall_i,
    input  logic            compressed_i,
    input  logic            exc_i,
    input  logic            eret_i,
    input  logic [XLEN-1:0] epc_i,
    input  logic            branch_i,
    input  logic [XLEN-1:0] branch_target_i,
    input  logic            halt_i,
    input  logic            resume_i,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_plus_o,
    output logic            pc_valid_o,
    output logic            misalign_o
);

    localparam logic [XLEN-1:0] RST_PC = XLEN'(RESET_VECTOR);
    localparam logic [XLEN-1:0] EXC_PC = XLEN'(EXC_VECTOR);
    // Bit 0 always cleared; bit 1 also cleared unless 16-bit instructions exist.
    localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, (C_EXT ? 2'b10 : 2'b00)};

    pc_state_t       state, state_next;
    redir_sel_t      sel;
    logic [XLEN-1:0] pc_q, pc_next, pc_inc, raw_target;
    logic            mis_q, mis_next;
    logic            accept;

    elbeth_pc_incr #(
        .XLEN (XLEN),
        .C_EXT(C_EXT)
    ) u_incr (
        .pc        (pc_q),
        .compressed(compressed_i),
        .sum       (pc_inc)
    );

    assign pc_o       = pc_q;
    assign pc_plus_o  = pc_inc;
    assign pc_valid_o = (state == ST_RUN);
    assign misalign_o = mis_q;
    assign accept     = pc_valid_o & fetch_ready_i & ~stall_i;

    always_comb begin
        sel = SEL_SEQ;
        if (state != ST_BOOT) begin
            if (exc_i)         sel = SEL_EXC;
            else if (eret_i)   sel = SEL_ERET;
            else if (branch_i) sel = SEL_BRANCH;
        end
    end

    always_comb begin
        raw_target = '0;
        case (sel)
            SEL_EXC:    raw_target = EXC_PC;
            SEL_ERET:   raw_target = epc_i;
            SEL_BRANCH: raw_target = branch_target_i;
            default:    raw_target = '0;
        endcase
    end

    always_comb begin
        state_next = state;
        pc_next    = pc_q;
        mis_next   = 1'b0;
        if (sel != SEL_SEQ) begin
            pc_next  = raw_target & ALIGN_MASK;
            mis_next = |(raw_target & ~ALIGN_MASK);
            if (sel == SEL_EXC) state_next = ST_RUN;
        end else begin
            case (state)
                ST_BOOT: state_next = ST_RUN;
                ST_RUN: begin
                    if (halt_i)      state_next = ST_HALT;
                    else if (accept) pc_next    = pc_inc;
                end
                ST_HALT: begin
                    if (resume_i) state_next = ST_RUN;
                end
                default: state_next = ST_BOOT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_BOOT;
            pc_q  <= RST_PC;
            mis_q <= 1'b0;
        end else begin
            state <= state_next;
            pc_q  <= pc_next;
            mis_q <= mis_next;
        end
    end

endmodule

// File: tb/tb_elbeth_pc_unit.sv
// Bench for elbeth_pc_unit: directed vector table, hand sequences, and random run vs reference model.
module tb_elbeth_pc_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy, stl, cmp, exc, eret, br, halt, res;
    logic [31:0] epc, tgt;
    logic [31:0] pc_a, plus_a, pc_c, plus_c;
    logic        v_a, m_a, v_c, m_c;

    int n_chk  = 0;
    int n_pass = 0;

    elbeth_pc_unit #(.XLEN(32), .C_EXT(1'b0)) dut_a (
        .clk(clk), .rst(rst), .fetch_ready_i(rdy), .stall_i(stl), .compressed_i(cmp),
        .exc_i(exc), .eret_i(eret), .epc_i(epc), .branch_i(br), .branch_target_i(tgt),
        .halt_i(halt), .resume_i(res), .pc_o(pc_a), .pc_plus_o(plus_a),
        .pc_valid_o(v_a), .misalign_o(m_a)
    );

    elbeth_pc_unit #(.XLEN(32), .C_EXT(1'b1)) dut_c (
        .clk(clk), .rst(rst), .fetch_ready_i(rdy), .stall_i(stl), .compressed_i(cmp),
        .exc_i(exc), .eret_i(eret), .epc_i(epc), .branch_i(br), .branch_target_i(tgt),
        .halt_i(halt), .resume_i(res), .pc_o(pc_c), .pc_plus_o(plus_c),
        .pc_valid_o(v_c), .misalign_o(m_c)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic drive(input logic r, s, c, e, er, b, h, rs, input logic [31:0] ep, tg);
        rdy = r; stl = s; cmp = c; exc = e; eret = er; br = b; halt = h; res = rs;
        epc = ep; tgt = tg;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: per-instance mode (0 boot, 1 run, 2 halt), PC and misalign flag.
    int          mode [2];
    logic [31:0] mpc  [2];
    logic        mmis [2];

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mode[i] = 0; mpc[i] = 32'h0; mmis[i] = 1'b0;
        end
    endtask

    task automatic model_edge(input int i);
        logic [31:0] mask, raw;
        mask = (i == 1) ? 32'hFFFF_FFFE : 32'hFFFF_FFFC;
        if (mode[i] == 0) begin
            mode[i] = 1;
            mmis[i] = 1'b0;
        end else if (exc || eret || br) begin
            raw     = exc ? 32'h100 : (eret ? epc : tgt);
            mmis[i] = (raw & ~mask) != 0;
            mpc[i]  = raw & mask;
            if (exc) mode[i] = 1;
        end else begin
            mmis[i] = 1'b0;
            if (mode[i] == 1) begin
                if (halt) mode[i] = 2;
                else if (rdy && !stl) mpc[i] = mpc[i] + (((i == 1) && cmp) ? 32'd2 : 32'd4);
            end else if (res) begin
                mode[i] = 1;
            end
        end
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
    endtask

    typedef struct {
        logic        rdy, stl, exc, eret, br, halt, res;
        logic [31:0] epc, tgt;
        logic [31:0] pc;
        logic        valid, mis;
    } vec_t;

    function automatic vec_t mk(logic r, s, e, er, b, h, rs, logic [31:0] ep, tg, p, logic v, m);
        vec_t x;
        x.rdy = r; x.stl = s; x.exc = e; x.eret = er; x.br = b; x.halt = h; x.res = rs;
        x.epc = ep; x.tgt = tg; x.pc = p; x.valid = v; x.mis = m;
        return x;
    endfunction

    vec_t vecs[$];

    initial begin
        // Directed table for the C_EXT=0 instance; each record is inputs then state after one edge.
        vecs.push_back(mk(1,0,0,0,0,0,0, 0, 0,          32'h0,   1, 0));
        vecs.push_back(mk(1,0,0,0,0,0,0, 0, 0,          32'h4,   1, 0));
        vecs.push_back(mk(1,0,0,0,0,0,0, 0, 0,          32'h8,   1, 0));
        vecs.push_back(mk(1,0,0,0,0,0,0, 0, 0,          32'hC,   1, 0));
        vecs.push_back(mk(1,0,0,0,0,0,0, 0, 0,          32'h10,  1, 0));
        vecs.push_back(mk(0,0,0,0,0,0,0, 0, 0,          32'h10,  1, 0));
        vecs.push_back(mk(0,0,0,0,0,0,0, 0, 0,          32'h10,  1, 0));
        vecs.push_back(mk(0,0,0,0,0,0,0, 0, 0,          32'h10,  1, 0));
        vecs.push_back(mk(1,0,0,0,0,0,0, 0, 0,          32'h14,  1, 0));
        vecs.push_back(mk(1,1,0,0,0,0,0, 0, 0,          32'h14,  1, 0));
        vecs.push_back(mk(1,1,0,0,0,0,0, 0, 0,          32'h14,  1, 0));
        vecs.push_back(mk(1,1,0,0,0,0,0, 0, 0,          32'h14,  1, 0));
        vecs.push_back(mk(1,0,0,0,0,0,0, 0, 0,          32'h18,  1, 0));
        vecs.push_back(mk(0,0,0,0,1,0,0, 0, 32'h200,    32'h200, 1, 0));
        vecs.push_back(mk(0,0,1,0,1,0,0, 0, 32'h300,    32'h100, 1, 0));
        vecs.push_back(mk(1,0,0,0,0,0,0, 0, 0,          32'h104, 1, 0));
        vecs.push_back(mk(0,0,0,0,1,0,0, 0, 32'h206,    32'h204, 1, 1));
        vecs.push_back(mk(0,0,0,0,0,0,0, 0, 0,          32'h204, 1, 0));
        vecs.push_back(mk(0,0,0,1,0,0,0, 32'h300, 0,    32'h300, 1, 0));
        vecs.push_back(mk(0,0,0,0,1,0,0, 0, 32'h80,     32'h80,  1, 0));
        vecs.push_back(mk(1,0,0,0,0,1,0, 0, 0,          32'h80,  0, 0));
        vecs.push_back(mk(1,0,0,0,0,0,0, 0, 0,          32'h80,  0, 0));
        vecs.push_back(mk(1,0,0,0,1,0,0, 0, 32'h90,     32'h90,  0, 0));
        vecs.push_back(mk(0,0,0,0,0,0,1, 0, 0,          32'h90,  1, 0));
        vecs.push_back(mk(1,0,0,0,0,0,0, 0, 0,          32'h94,  1, 0));
        vecs.push_back(mk(1,0,0,0,1,1,0, 0, 32'h40,     32'h40,  1, 0));
        vecs.push_back(mk(1,0,0,0,0,1,0, 0, 0,          32'h40,  0, 0));
        vecs.push_back(mk(1,0,0,0,0,0,1, 0, 0,          32'h40,  1, 0));
        vecs.push_back(mk(1,0,0,0,0,0,0, 0, 0,          32'h44,  1, 0));
        vecs.push_back(mk(0,0,0,0,1,0,0, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1, 0));
        vecs.push_back(mk(1,0,0,0,0,0,0, 0, 0,          32'h0,   1, 0));
        vecs.push_back(mk(0,0,0,0,0,1,0, 0, 0,          32'h0,   0, 0));
        vecs.push_back(mk(0,0,1,0,0,0,0, 0, 0,          32'h100, 1, 0));
        vecs.push_back(mk(0,0,0,1,0,0,0, 32'h301, 0,    32'h300, 1, 1));
        vecs.push_back(mk(1,0,0,0,0,0,0, 0, 0,          32'h304, 1, 0));

        // Reset state.
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        #3;
        chk("reset_pc", pc_a, 32'h0);
        chk("reset_valid", {31'b0, v_a}, 32'h0);
        chk("reset_mis", {31'b0, m_a}, 32'h0);
        tick();
        rst = 1'b0;
        chk("boot_valid", {31'b0, v_a}, 32'h0);

        foreach (vecs[k]) begin
            drive(vecs[k].rdy, vecs[k].stl, 1'b0, vecs[k].exc, vecs[k].eret, vecs[k].br,
                  vecs[k].halt, vecs[k].res, vecs[k].epc, vecs[k].tgt);
            tick();
            chk($sformatf("vec%0d_pc", k), pc_a, vecs[k].pc);
            chk($sformatf("vec%0d_valid", k), {31'b0, v_a}, {31'b0, vecs[k].valid});
            chk($sformatf("vec%0d_mis", k), {31'b0, m_a}, {31'b0, vecs[k].mis});
            chk($sformatf("vec%0d_plus", k), plus_a, vecs[k].pc + 32'd4);
        end

        // Compressed stepping: C_EXT=1 honours compressed_i, C_EXT=0 always steps 4.
        do_reset();
        tick();
        drive(0, 0, 0, 0, 0, 1, 0, 0, 0, 32'h40);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h40);
        br = 1'b1;
        tick();
        chk("cx_branch_c", pc_c, 32'h40);
        chk("cx_branch_a", pc_a, 32'h40);
        drive(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("cx_plus_c", plus_c, 32'h42);
        chk("cx_plus_a", plus_a, 32'h44);
        tick();
        chk("cx_step1_c", pc_c, 32'h42);
        chk("cx_step1_a", pc_a, 32'h44);
        tick();
        chk("cx_step2_c", pc_c, 32'h44);
        chk("cx_step2_a", pc_a, 32'h48);
        cmp = 1'b0;
        tick();
        chk("cx_step3_c", pc_c, 32'h48);
        chk("cx_step3_a", pc_a, 32'h4C);
        drive(0, 0, 0, 0, 0, 1, 0, 0, 0, 32'h207);
        tick();
        chk("cx_align_c", pc_c, 32'h206);
        chk("cx_mis_c", {31'b0, m_c}, 32'h1);
        chk("cx_align_a", pc_a, 32'h204);
        chk("cx_mis_a", {31'b0, m_a}, 32'h1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("cx_mis_clear_c", {31'b0, m_c}, 32'h0);
        chk("cx_mis_clear_a", {31'b0, m_a}, 32'h0);

        // Asynchronous reset in the middle of running.
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        chk("arst_pre_pc", pc_a, 32'h20C);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_pc", pc_a, 32'h0);
        chk("arst_valid", {31'b0, v_a}, 32'h0);
        chk("arst_pc_c", pc_c, 32'h0);
        tick();
        rst = 1'b0;

        // Randomized run against the reference model, both instances.
        do_reset();
        for (int n = 0; n < 400; n++) begin
            rdy  = ($urandom_range(0, 3) != 0);
            stl  = ($urandom_range(0, 4) == 0);
            cmp  = $urandom_range(0, 1);
            exc  = ($urandom_range(0, 19) == 0);
            eret = ($urandom_range(0, 19) == 0);
            br   = ($urandom_range(0, 9) == 0);
            halt = ($urandom_range(0, 11) == 0);
            res  = ($urandom_range(0, 4) == 0);
            epc  = $urandom;
            tgt  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            @(posedge clk);
            model_edge(0);
            model_edge(1);
            #1;
            chk($sformatf("rnd%0d_pc_a", n), pc_a, mpc[0]);
            chk($sformatf("rnd%0d_valid_a", n), {31'b0, v_a}, {31'b0, mode[0] == 1});
            chk($sformatf("rnd%0d_mis_a", n), {31'b0, m_a}, {31'b0, mmis[0]});
            chk($sformatf("rnd%0d_plus_a", n), plus_a, mpc[0] + 32'd4);
            chk($sformatf("rnd%0d_pc_c", n), pc_c, mpc[1]);
            chk($sformatf("rnd%0d_valid_c", n), {31'b0, v_c}, {31'b0, mode[1] == 1});
            chk($sformatf("rnd%0d_mis_c", n), {31'b0, m_c}, {31'b0, mmis[1]});
            chk($sformatf("rnd%0d_plus_c", n), plus_c, mpc[1] + (cmp ? 32'd2 : 32'd4));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/elbeth_pc_unit.md
Name: elbeth_pc_unit

Overview:
- Parametrised program-counter unit: PC register, sequential incrementer (+2 or +4), redirect mux and fetch handshake.
- Sits at the head of the fetch stage. Supplies the current fetch address to instruction memory and the link value (PC+step) to decode/writeback.
- Accepts exception, exception-return and branch/jump redirects from later stages.

Parameters:
- XLEN, 32, address/PC width in bits.
- RESET_VECTOR, 32'h0000_0000, PC loaded on leaving BOOT; truncated to XLEN.
- EXC_VECTOR, 32'h0000_0100, PC loaded on exception; truncated to XLEN.
- C_EXT, 0, 1 enables 16-bit step (compressed_i honoured) and 2-byte target alignment.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- fetch_ready_i  in  1  instruction memory accepts pc_o this cycle.
- stall_i  in  1  pipeline stall; PC holds, no acceptance.
- compressed_i  in  1  instruction at pc_o is 16-bit; ignored when C_EXT=0.
- exc_i  in  1  exception redirect to EXC_VECTOR.
- eret_i  in  1  exception-return redirect to epc_i.
- epc_i  in  XLEN  return address.
- branch_i  in  1  taken branch/jump redirect.
- branch_target_i  in  XLEN  branch/jump target.
- halt_i  in  1  enter HALT.
- resume_i  in  1  leave HALT.
- pc_o  out  XLEN  current fetch address.
- pc_plus_o  out  XLEN  pc_o + step, combinational from pc_o and compressed_i.
- pc_valid_o  out  1  pc_o is a valid fetch request.
- misalign_o  out  1  registered one-cycle pulse: the redirect target was misaligned.

Behaviour:
- Reset (async): state=BOOT, pc_o=RESET_VECTOR, pc_valid_o=0, misalign_o=0.
- FSM states:
  - BOOT→RUN on the first clock edge after reset deassert; pc_valid_o=0 in BOOT.
  - RUN→HALT on halt_i when no redirect is pending. Redirect has priority; halt_i is re-sampled next cycle.
  - HALT→RUN on resume_i; pc_valid_o=0 in HALT.
  - exc_i in HALT loads EXC_VECTOR and goes to RUN. Other redirects in HALT load the PC and stay in HALT.
- Step = 2 when C_EXT=1 and compressed_i=1; otherwise 4.
- Acceptance = state RUN & pc_valid_o & fetch_ready_i & ~stall_i. On acceptance, pc_o <= pc_o + step on the next edge.
- Redirect priority, every clock in RUN or HALT: exc_i > eret_i > branch_i > sequential.
- Redirects ignore fetch_ready_i and stall_i; they take effect on the next edge, and the pending request is abandoned.
- Single-cycle latency: redirect asserted in cycle N gives the new pc_o in cycle N+1, with pc_valid_o=1 if in RUN.
- Alignment: redirect targets have bit0 forced to 0. When C_EXT=0, bits[1:0] are forced to 0.
- misalign_o=1 for exactly one cycle after a redirect whose raw target had any forced bit set.
- Arithmetic: unsigned modulo 2^XLEN. PC 'hFFFF_FFFC + 4 wraps to 0 with no flag. pc_plus_o wraps identically.
- Stall with no redirect: pc_o and pc_valid_o hold, pc_plus_o stays stable.
- Simultaneous exc_i & branch_i: exception wins, and the branch is dropped (not remembered).
- Reset asserted mid-operation: immediate return to BOOT values regardless of clock.

Decomposition:
- Package elbeth_pc_pkg:
  - FSM state encoding (BOOT, RUN, HALT).
  - Step constants STEP16=2 and STEP32=4.
  - Redirect-select encoding.
- Sub-module elbeth_pc_incr: combinational XLEN-parametrised incrementer, out = in + (c_ext & compressed ? 2 : 4). Instantiated once; it feeds both pc_plus_o and the next-PC mux.

Test Plan:
- Reset release with fetch_ready_i=1 → one cycle pc_valid_o=0, then pc_o=0x0, 0x4, 0x8 on consecutive cycles; pc_plus_o=0x4, 0x8, 0xC.
- fetch_ready_i=0 for 3 cycles at pc_o=0x10 → pc_o holds 0x10 with pc_valid_o=1. Then ready=1 → 0x14 next cycle. Repeat with stall_i=1: same hold.
- branch_i=1, target=0x200, fetch_ready_i=0 → pc_o=0x200 next cycle. Same cycle with exc_i=1 → pc_o=0x100 and the branch is lost.
- C_EXT=1, pc_o=0x40, compressed_i=1,1,0 → pc_o=0x42, 0x44, 0x48. With C_EXT=0, compressed_i=1 still steps by 4.
- C_EXT=0 branch target 0x206 → pc_o=0x204 and misalign_o pulses 1 cycle. eret_i with epc_i=0x300 → pc_o=0x300, misalign_o=0.
- halt_i at pc_o=0x80 → pc_valid_o=0 and pc held; branch to 0x90 while halted → pc_o=0x90, still HALT; resume_i → pc_valid_o=1 at 0x90. Also check: pc 0xFFFF_FFFC accepted → 0x0; rst pulse mid-run → pc_o=0x0, pc_valid_o=0 asynchronously.
